// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single data-memory port. Every access is a strobe-then-wait
// transaction, and the address stays on mem_addr until the next grant.
module mem_bus_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_write,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_read,
    output logic        busy,
    output logic        owner
);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int LW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_write_q, mem_write_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [15:0]   m0_rdata_q, m0_rdata_d;
    logic [15:0]   m1_rdata_q, m1_rdata_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          grant_m1;
    logic [LW-1:0] lock_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;  // m0 wins the first tie
            we_q        <= 1'b0;
            wait_q      <= '0;
            lock_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            lock_q      <= lock_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        wait_d      = wait_q;
        lock_d      = lock_q;
        grant_m1    = 1'b0;
        lock_inc    = lock_q + LW'(1);

        case (state_q)
            IDLE: begin
                // A lock only survives while m1 keeps asking.
                if (lock_q != '0 && !m1_req) begin
                    lock_d = '0;
                end
                if (m0_req || m1_req) begin
                    if (lock_q != '0 && m1_req) begin
                        grant_m1 = 1'b1;
                    end else if (m0_req && m1_req) begin
                        grant_m1 = (FIXED_PRIO == 0) && !last_q;
                    end else begin
                        grant_m1 = m1_req;
                    end
                    owner_d     = grant_m1;
                    last_d      = grant_m1;
                    we_d        = grant_m1 ? m1_we : m0_we;
                    mem_addr_d  = grant_m1 ? m1_addr : m0_addr;
                    mem_write_d = grant_m1 ? m1_wdata : m0_wdata;
                    mem_we_d    = we_d;
                    mem_re_d    = !we_d;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    m0_ack_d = !owner_q;
                    m1_ack_d = owner_q;
                    state_d  = ACK;
                end else begin
                    wait_d  = CW'(READ_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    if (owner_q) begin
                        m1_rdata_d = mem_read;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = mem_read;
                        m0_ack_d   = 1'b1;
                    end
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                // Reaching LOCK_MAX clears the count, so plain arbitration hands m0 the next tie.
                if (owner_q) begin
                    if (m1_lock && lock_inc < LW'(LOCK_MAX)) begin
                        lock_d = lock_inc;
                    end else begin
                        lock_d = '0;
                    end
                end
            end
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (RL=1 round-robin, RL=3 fixed priority) share stimulus
// and are checked every cycle against a latency-formula transaction model.
module tb_mem_bus_arbiter;
    localparam int RL_A = 1, RL_B = 3, FP_A = 0, FP_B = 1, LMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;

    logic        d_m0_ack[2], d_m1_ack[2], d_we[2], d_re[2], d_busy[2], d_owner[2];
    logic [15:0] d_m0_rdata[2], d_m1_rdata[2], d_wdata[2], d_mread[2];
    logic [31:0] d_addr[2];

    int cyc = 0;
    int sc[2] = '{-100, -100};

    function automatic logic [15:0] memf(input logic [31:0] a);
        return (a == 32'h10000004) ? 16'h1234 : (a[15:0] ^ a[31:16] ^ 16'h3C3C);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_bus_arbiter #(
            .READ_LAT  (gi == 0 ? RL_A : RL_B),
            .FIXED_PRIO(gi == 0 ? FP_A : FP_B),
            .LOCK_MAX  (LMAX)
        ) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_ack(d_m0_ack[gi]), .m0_rdata(d_m0_rdata[gi]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_ack(d_m1_ack[gi]), .m1_rdata(d_m1_rdata[gi]), .m1_lock(m1_lock),
            .mem_addr(d_addr[gi]), .mem_write(d_wdata[gi]), .mem_we(d_we[gi]), .mem_re(d_re[gi]),
            .mem_read(d_mread[gi]), .busy(d_busy[gi]), .owner(d_owner[gi])
        );
        // Memory shows garbage until READ_LAT cycles after the strobe was raised.
        assign d_mread[gi] = ((cyc - sc[gi]) >= (gi == 0 ? RL_A : RL_B)) ? memf(d_addr[gi]) : 16'hDEAD;
    end

    logic        s_rst = 1'b1, s_m0_req, s_m0_we, s_m1_req, s_m1_we, s_m1_lock;
    logic [31:0] s_m0_addr, s_m1_addr;
    logic [15:0] s_m0_wdata, s_m1_wdata;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        s_rst <= rst;  s_m0_req <= m0_req;  s_m0_we <= m0_we;  s_m1_req <= m1_req;
        s_m1_we <= m1_we;  s_m1_lock <= m1_lock;  s_m0_addr <= m0_addr;  s_m1_addr <= m1_addr;
        s_m0_wdata <= m0_wdata;  s_m1_wdata <= m1_wdata;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) if (d_re[i]) sc[i] <= cyc;
    end

    // Model: a transaction granted at edge g acks at g+1 (write) or g+1+RL (read), frees the bus two edges later.
    int          e = 0;
    int          free_at[2], grant_at[2], ack_at[2], x_lock[2];
    logic        x_owner[2], x_last[2], x_we[2];
    logic [31:0] x_addr[2];
    logic [15:0] x_wdata[2], x_rd0[2], x_rd1[2];
    int          mg_n[2] = '{0, 0}, dg_n[2] = '{0, 0};
    int          mg_log[2][64], dg_log[2][64];
    int          err_cnt = 0, chk_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        free_at[i] = 0;  grant_at[i] = -100;  ack_at[i] = -100;  x_lock[i] = 0;
        x_owner[i] = 1'b0;  x_last[i] = 1'b1;  x_we[i] = 1'b0;
        x_addr[i] = '0;  x_wdata[i] = '0;  x_rd0[i] = '0;  x_rd1[i] = '0;
    endtask

    task automatic model_step(input int i);
        int  rl;
        bit  fp;
        bit  w;
        rl = (i == 0) ? RL_A : RL_B;
        fp = (((i == 0) ? FP_A : FP_B) != 0);
        if (e == ack_at[i] && !x_we[i]) begin
            if (x_owner[i]) x_rd1[i] = memf(x_addr[i]);
            else            x_rd0[i] = memf(x_addr[i]);
        end
        if (e == ack_at[i] + 1 && x_owner[i])
            x_lock[i] = s_m1_lock ? ((x_lock[i] + 1 >= LMAX) ? 0 : x_lock[i] + 1) : 0;
        if (e >= free_at[i]) begin
            if (x_lock[i] != 0 && !s_m1_req) x_lock[i] = 0;
            if (s_m0_req || s_m1_req) begin
                if (x_lock[i] != 0)             w = 1'b1;
                else if (s_m0_req && s_m1_req)  w = fp ? 1'b0 : !x_last[i];
                else                            w = s_m1_req;
                x_owner[i] = w;  x_last[i] = w;
                x_we[i]    = w ? s_m1_we : s_m0_we;
                x_addr[i]  = w ? s_m1_addr : s_m0_addr;
                x_wdata[i] = w ? s_m1_wdata : s_m0_wdata;
                grant_at[i] = e;
                ack_at[i]   = e + (x_we[i] ? 1 : 1 + rl);
                free_at[i]  = ack_at[i] + 2;
                if (mg_n[i] < 64) begin mg_log[i][mg_n[i]] = int'(w); mg_n[i]++; end
                $display("txn dut=%0d master=%0d %s addr=%h wdata=%h", i, w, x_we[i] ? "wr" : "rd",
                         x_addr[i], x_wdata[i]);
            end
        end
    endtask

    task automatic compare(input int i);
        chk($sformatf("e%0d dut%0d mem_addr", e, i), d_addr[i], x_addr[i]);
        chk($sformatf("e%0d dut%0d mem_write", e, i), d_wdata[i], x_wdata[i]);
        chk($sformatf("e%0d dut%0d we_re", e, i), {d_we[i], d_re[i]},
            {grant_at[i] == e && x_we[i], grant_at[i] == e && !x_we[i]});
        chk($sformatf("e%0d dut%0d acks", e, i), {d_m0_ack[i], d_m1_ack[i]},
            {ack_at[i] == e && !x_owner[i], ack_at[i] == e && x_owner[i]});
        chk($sformatf("e%0d dut%0d rdata", e, i), {d_m0_rdata[i], d_m1_rdata[i]}, {x_rd0[i], x_rd1[i]});
        chk($sformatf("e%0d dut%0d busy_owner", e, i), {d_busy[i], d_owner[i]},
            {e >= grant_at[i] && e <= ack_at[i], x_owner[i]});
    endtask

    initial forever begin
        @(negedge clk);
        e++;
        for (int i = 0; i < 2; i++) begin
            if (rst || s_rst) begin
                model_reset(i);
            end else begin
                model_step(i);
                compare(i);
                if ((d_we[i] || d_re[i]) && dg_n[i] < 64) begin
                    dg_log[i][dg_n[i]] = int'(d_owner[i]);
                    dg_n[i]++;
                end
            end
        end
    end

    task automatic measure(input int k0, output int la, output int lb,
                           output logic [15:0] ra, output logic [15:0] rb);
        la = 0;  lb = 0;  ra = '0;  rb = '0;
        for (int k = k0 + 1; k <= 40 && (la == 0 || lb == 0); k++) begin
            @(negedge clk);
            if (la == 0 && d_m0_ack[0]) begin la = k; ra = d_m0_rdata[0]; end
            if (lb == 0 && d_m0_ack[1]) begin lb = k; rb = d_m0_rdata[1]; end
        end
    endtask

    int exp_lock[5] = '{1, 1, 1, 1, 0};
    int exp_rr_a[4] = '{0, 1, 0, 1};
    int exp_rr_b[4] = '{0, 0, 0, 0};

    initial begin
        int la, lb, sa, sb, ma, mb, n_ack;
        logic [15:0] ra, rb;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_state dut%0d", i),
                {d_addr[i], d_wdata[i], d_we[i], d_re[i], d_m0_ack[i], d_m1_ack[i], d_busy[i], d_owner[i]}, '0);
            chk($sformatf("reset_rdata dut%0d", i), {d_m0_rdata[i], d_m1_rdata[i]}, '0);
        end
        @(posedge clk); #2 rst = 1'b0;

        // Single m0 write
        @(negedge clk);
        m0_req = 1'b1;  m0_we = 1'b1;  m0_addr = 32'hD0000010;  m0_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr_strobe", {d_we[0], d_we[1], d_re[0], d_re[1]}, 4'b1100);
        chk("wr_addr", {d_addr[0], d_addr[1]}, {32'hD0000010, 32'hD0000010});
        chk("wr_data", {d_wdata[0], d_wdata[1]}, {16'hBEEF, 16'hBEEF});
        measure(1, la, lb, ra, rb);
        m0_req = 1'b0;
        chk("wr_lat_a", la, 2);
        chk("wr_lat_b", lb, 2);
        repeat (4) @(negedge clk);

        // m0 read of 0x10000004
        m0_req = 1'b1;  m0_we = 1'b0;  m0_addr = 32'h10000004;
        @(negedge clk);
        chk("rd_strobe", {d_we[0], d_we[1], d_re[0], d_re[1]}, 4'b0011);
        measure(1, la, lb, ra, rb);
        m0_req = 1'b0;
        chk("rd_lat_a", la, 3);
        chk("rd_lat_b", lb, 5);
        chk("rd_data_a", ra, 16'h1234);
        chk("rd_data_b", rb, 16'h1234);
        repeat (8) @(negedge clk);

        // m1 locked burst with m0 contending
        sa = dg_n[0];  sb = dg_n[1];  ma = mg_n[0];  mb = mg_n[1];
        m1_req = 1'b1;  m1_we = 1'b1;  m1_lock = 1'b1;  m1_addr = 32'h00000200;  m1_wdata = 16'h0A0A;
        @(negedge clk);
        m0_req = 1'b1;  m0_we = 1'b1;  m0_addr = 32'h00000100;  m0_wdata = 16'h5555;
        for (int k = 0; k < 80 && (dg_n[0] - sa < 5 || dg_n[1] - sb < 5); k++) @(negedge clk);
        m0_req = 1'b0;  m1_req = 1'b0;  m1_lock = 1'b0;
        repeat (6) @(negedge clk);
        chk("lock_grants_seen", {dg_n[0] - sa >= 5, dg_n[1] - sb >= 5}, 2'b11);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lock_grant%0d dut0", k), dg_log[0][sa + k], exp_lock[k]);
            chk($sformatf("lock_grant%0d dut1", k), dg_log[1][sb + k], exp_lock[k]);
            chk($sformatf("lock_grant%0d model0", k), mg_log[0][ma + k], exp_lock[k]);
            chk($sformatf("lock_grant%0d model1", k), mg_log[1][mb + k], exp_lock[k]);
        end

        // Reset while the RL=3 instance waits on a read
        m0_req = 1'b1;  m0_we = 1'b0;  m0_addr = 32'h10000004;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy_b", d_busy[1], 1);
        @(posedge clk); #2 rst = 1'b1;  m0_req = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("rst_async dut%0d", i),
                {d_we[i], d_re[i], d_m0_ack[i], d_m1_ack[i], d_busy[i]}, '0);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
        n_ack = 0;
        repeat (8) begin
            @(negedge clk);
            n_ack += int'(d_m0_ack[0]) + int'(d_m0_ack[1]) + int'(d_m1_ack[0]) + int'(d_m1_ack[1]);
        end
        chk("no_ack_after_rst", n_ack, 0);

        // Both masters hold req: first tie after reset goes to m0
        sa = dg_n[0];  sb = dg_n[1];  ma = mg_n[0];  mb = mg_n[1];
        m0_req = 1'b1;  m0_we = 1'b1;  m0_addr = 32'h00000300;  m0_wdata = 16'h1111;
        m1_req = 1'b1;  m1_we = 1'b1;  m1_addr = 32'h00000400;  m1_wdata = 16'h2222;
        for (int k = 0; k < 80 && (dg_n[0] - sa < 4 || dg_n[1] - sb < 4); k++) @(negedge clk);
        m0_req = 1'b0;  m1_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("tie_grants_seen", {dg_n[0] - sa >= 4, dg_n[1] - sb >= 4}, 2'b11);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d dut0", k), dg_log[0][sa + k], exp_rr_a[k]);
            chk($sformatf("fp_grant%0d dut1", k), dg_log[1][sb + k], exp_rr_b[k]);
            chk($sformatf("rr_grant%0d model0", k), mg_log[0][ma + k], exp_rr_a[k]);
            chk($sformatf("fp_grant%0d model1", k), mg_log[1][mb + k], exp_rr_b[k]);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
